ofdm_periodic_framer: RTL and testbench
=======================================

Name: ofdm_periodic_framer

Overview:
- Streaming framer placed after the Schmidl-Cox detector and ahead of the FFT in the OFDM receive chain.
- A detection strobe arrives on i_tuser. The block drops a programmable offset, then emits up to max_frames frames of frame_len samples.
- It drops gap_len samples (the cyclic prefix) between consecutive frames.
- Generalises the fixed 64/16 framer: parametrised sample width, counter widths, settings base address, and unlimited-frame mode.

Parameters:
- WIDTH, 32, sample width in bits (I/Q packed).
- LEN_W, 16, width of frame_len, gap_len and offset registers and their counters.
- CNT_W, 8, width of the max_frames register and the frame counter.
- SR_BASE, 8'h10, settings-bus base address.
- DEF_FRAME_LEN, 64, reset value of frame_len.
- DEF_GAP_LEN, 16, reset value of gap_len.

Ports:
- ce_clk  in  1  clock
- ce_rst  in  1  reset; asynchronous, active-low
- set_stb  in  1  settings write strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- i_tdata  in  WIDTH  input sample
- i_tuser  in  1  trigger strobe, qualified by i_tvalid
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  WIDTH  output sample
- o_tlast  out  1  last sample of each frame
- o_teob  out  1  asserted with o_tlast on the final frame of a burst
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready
- frame_cnt  out  CNT_W  frames completed in the current burst
- busy  out  1  state != IDLE

Behaviour:
- Reset: ce_rst is asynchronous, active-low; clock is ce_clk.
- Values while ce_rst=0:
  - state=IDLE; all counters 0; frame_cnt=0; busy=0; o_tvalid=0; o_tlast=0; o_teob=0.
  - Registers: frame_len=DEF_FRAME_LEN, gap_len=DEF_GAP_LEN, offset=0, max_frames=0.
- Settings: a write at SR_BASE+0/+1/+2/+3 loads frame_len/gap_len/offset/max_frames from set_data[LEN_W-1:0] or [CNT_W-1:0].
  - Values are copied into shadow registers at trigger acceptance. Writes during a burst do not affect that burst.
  - frame_len=0 is clamped to 1. max_frames=0 means unlimited.
- Accepted sample: i_tvalid && i_tready. All counters advance only on accepted samples.
- IDLE: i_tready=1, samples discarded. An accepted sample with i_tuser=1 latches the shadows and sets frame_cnt=0.
  - offset=0: that trigger sample is frame sample 0 and the state goes to FRAME (counter=1).
  - Otherwise: trigger sample is offset sample 0, state goes to OFFSET (counter=1).
- OFFSET: i_tready=1, samples discarded. When offset samples in total have been consumed, go to FRAME.
- FRAME: zero-latency pass-through.
  - o_tdata=i_tdata, o_tvalid=i_tvalid, i_tready=o_tready.
  - o_tlast=1 on sample frame_len-1.
  - On the tlast handshake frame_cnt increments, then:
    - frame_cnt+1 == max_frames (max_frames!=0): o_teob=1 on that sample, go to IDLE.
    - else gap_len=0: stay in FRAME.
    - else: go to GAP.
- GAP: i_tready=1, discard gap_len samples, then go to FRAME.
- i_tuser is ignored outside IDLE, unless the optional feature is enabled.
- frame_cnt saturates at all-ones in unlimited mode; framing continues.
- Backpressure never drops or duplicates a sample. Counters hold while o_tready=0.
- Asynchronous reset mid-frame returns to IDLE immediately. No tlast is generated for the truncated frame.
- Latency: 0 cycles in FRAME. Output is combinational from the input; no internal buffering.

Optional Feature:
- Macro: OFDM_FRAMER_RETRIGGER_EN.
- Defined:
  - An accepted i_tuser=1 in OFFSET or GAP restarts the burst exactly as from IDLE: shadows reloaded, frame_cnt=0, offset counting restarts with that sample.
  - A trigger in FRAME is held as a pending flag. After the current frame's tlast handshake, the burst restarts with frame_cnt=0, using the next accepted sample as offset sample 0. The frame is never truncated, and o_teob=1 on that tlast.
- Undefined: triggers are ignored outside IDLE; no pending flag logic is synthesised.

Test Plan:
- Defaults, max_frames=2, offset=30; trigger on sample 100 of a ramp -> frames carry ramp values 130..193 and 210..273; tlast on 193 and 273; teob on 273; frame_cnt=2; busy=0 afterwards.
- offset=0, gap_len=0, frame_len=4, max_frames=3; trigger on sample 5 -> output 5..16 contiguous; tlast on 8,12,16; teob on 16.
- Randomised o_tready (50%) during the first test -> output sequence identical; no gaps or duplicates in ramp values.
- Write frame_len=32 mid-burst -> current burst keeps 64. Next trigger yields 32-sample frames.
- max_frames=0, frame_len=8, gap=2 -> framing continues past 300 frames; frame_cnt holds 255.
- With OFDM_FRAMER_RETRIGGER_EN, second trigger during GAP at sample 200 -> offset restarts from 200 and frame_cnt resets to 0. Without it -> second trigger ignored.

Source files
------------

// File: rtl/ofdm_periodic_framer.sv
// Purpose: cuts a detector-triggered sample stream into frames, skipping an offset and the gaps between frames.
// Latency: 0 cycles in FRAME (combinational pass-through); no internal buffering.
// Backpressure: o_tready feeds i_tready for framed samples; discarded samples are always accepted.
// Optional retrigger behaviour is enabled by defining OFDM_FRAMER_RETRIGGER_EN.
module ofdm_periodic_framer #(
    parameter int          WIDTH         = 32,
    parameter int          LEN_W         = 16,
    parameter int          CNT_W         = 8,
    parameter logic [7:0]  SR_BASE       = 8'h10,
    parameter int          DEF_FRAME_LEN = 64,
    parameter int          DEF_GAP_LEN   = 16
) (
    input  logic             ce_clk,
    input  logic             ce_rst,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tuser,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_teob,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_OFFSET = 2'd1;
    localparam logic [1:0] S_FRAME  = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    localparam logic [7:0]       A_FRAME_LEN = SR_BASE;
    localparam logic [7:0]       A_GAP_LEN   = SR_BASE + 8'd1;
    localparam logic [7:0]       A_OFFSET    = SR_BASE + 8'd2;
    localparam logic [7:0]       A_MAX       = SR_BASE + 8'd3;
    localparam logic [LEN_W-1:0] ONE_L       = 1;
    localparam logic [CNT_W-1:0] ONE_C       = 1;

    logic [LEN_W-1:0] frame_len_r, gap_len_r, offset_r;
    logic [CNT_W-1:0] max_frames_r;
    logic [LEN_W-1:0] sh_len, sh_gap, sh_off;
    logic [CNT_W-1:0] sh_max;
    logic [LEN_W-1:0] frame_len_cl;

    logic [1:0]       state, nxt_state;
    logic [LEN_W-1:0] cnt, nxt_cnt;
    logic [CNT_W-1:0] nxt_fc;
    logic             load_sh;

    logic             trig_state, trig, in_frame, is_last, accept, end_burst, pend_now;
    logic [LEN_W-1:0] eff_len, eff_gap, fidx;
    logic [CNT_W-1:0] eff_max, cnt_base, cnt_inc;

    logic unused_set_data;
    assign unused_set_data = ^set_data[31:LEN_W];

    always_ff @(posedge ce_clk or negedge ce_rst) begin
        if (!ce_rst) begin
            frame_len_r  <= LEN_W'(DEF_FRAME_LEN);
            gap_len_r    <= LEN_W'(DEF_GAP_LEN);
            offset_r     <= '0;
            max_frames_r <= '0;
        end else if (set_stb) begin
            case (set_addr)
                A_FRAME_LEN: frame_len_r  <= set_data[LEN_W-1:0];
                A_GAP_LEN:   gap_len_r    <= set_data[LEN_W-1:0];
                A_OFFSET:    offset_r     <= set_data[LEN_W-1:0];
                A_MAX:       max_frames_r <= set_data[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    assign frame_len_cl = (frame_len_r == '0) ? ONE_L : frame_len_r;

`ifdef OFDM_FRAMER_RETRIGGER_EN
    logic pend, nxt_pend;
    assign trig_state = (state != S_FRAME);
    // A trigger seen on the closing sample of a frame counts as pending too.
    assign pend_now   = (state == S_FRAME) && (pend || i_tuser);
`else
    assign trig_state = (state == S_IDLE);
    assign pend_now   = 1'b0;
`endif

    // A trigger sample is judged against the live registers, since shadows load on that same edge.
    assign trig     = i_tvalid && i_tuser && trig_state;
    assign eff_len  = trig ? frame_len_cl : sh_len;
    assign eff_gap  = trig ? gap_len_r : sh_gap;
    assign eff_max  = trig ? max_frames_r : sh_max;
    assign in_frame = (state == S_FRAME) || (trig && offset_r == '0);
    assign fidx     = trig ? '0 : cnt;
    assign is_last  = in_frame && (fidx == eff_len - ONE_L);
    assign cnt_base = trig ? '0 : frame_cnt;
    assign cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + ONE_C;
    assign end_burst = (eff_max != '0) && (cnt_base + ONE_C == eff_max);

    assign o_tdata  = i_tdata;
    assign o_tvalid = in_frame && i_tvalid;
    assign o_tlast  = o_tvalid && is_last;
    assign o_teob   = o_tlast && (end_burst || pend_now);
    assign i_tready = in_frame ? o_tready : 1'b1;
    assign accept   = i_tvalid && i_tready;
    assign busy     = (state != S_IDLE);

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_fc    = frame_cnt;
        load_sh   = 1'b0;
`ifdef OFDM_FRAMER_RETRIGGER_EN
        nxt_pend  = pend;
`endif
        if (accept) begin
            if (trig) begin
                load_sh = 1'b1;
                nxt_fc  = '0;
`ifdef OFDM_FRAMER_RETRIGGER_EN
                nxt_pend = 1'b0;
`endif
                if (offset_r == '0) begin
                    nxt_state = S_FRAME;
                    nxt_cnt   = ONE_L;
                end else if (offset_r == ONE_L) begin
                    nxt_state = S_FRAME;
                    nxt_cnt   = '0;
                end else begin
                    nxt_state = S_OFFSET;
                    nxt_cnt   = ONE_L;
                end
            end else begin
                case (state)
                    S_OFFSET: begin
                        nxt_cnt = cnt + ONE_L;
                        if (cnt + ONE_L == sh_off) begin
                            nxt_state = S_FRAME;
                            nxt_cnt   = '0;
                        end
                    end
                    S_GAP: begin
                        nxt_cnt = cnt + ONE_L;
                        if (cnt + ONE_L == sh_gap) begin
                            nxt_state = S_FRAME;
                            nxt_cnt   = '0;
                        end
                    end
                    S_FRAME: begin
                        nxt_cnt = cnt + ONE_L;
`ifdef OFDM_FRAMER_RETRIGGER_EN
                        if (i_tuser) nxt_pend = 1'b1;
`endif
                    end
                    default: ;
                endcase
            end

            // End-of-frame handling overrides the per-state counting above.
            if (is_last) begin
                nxt_fc  = cnt_inc;
                nxt_cnt = '0;
                if (end_burst) begin
                    nxt_state = S_IDLE;
                end else if (pend_now) begin
                    load_sh   = 1'b1;
                    nxt_fc    = '0;
                    nxt_state = (offset_r == '0) ? S_FRAME : S_OFFSET;
                end else begin
                    nxt_state = (eff_gap == '0) ? S_FRAME : S_GAP;
                end
`ifdef OFDM_FRAMER_RETRIGGER_EN
                nxt_pend = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge ce_clk or negedge ce_rst) begin
        if (!ce_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            frame_cnt <= '0;
            sh_len    <= LEN_W'(DEF_FRAME_LEN);
            sh_gap    <= LEN_W'(DEF_GAP_LEN);
            sh_off    <= '0;
            sh_max    <= '0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            frame_cnt <= nxt_fc;
            if (load_sh) begin
                sh_len <= frame_len_cl;
                sh_gap <= gap_len_r;
                sh_off <= offset_r;
                sh_max <= max_frames_r;
            end
        end
    end

`ifdef OFDM_FRAMER_RETRIGGER_EN
    always_ff @(posedge ce_clk or negedge ce_rst) begin
        if (!ce_rst) pend <= 1'b0;
        else         pend <= nxt_pend;
    end
`endif

endmodule

// File: tb/tb_ofdm_periodic_framer.sv
// Scoreboard bench: a ramp is framed by arithmetic rules, the monitor compares every output beat.
module tb_ofdm_periodic_framer;

    localparam logic [7:0] BASE = 8'h10;

    logic        ce_clk = 1'b0;
    logic        ce_rst = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [31:0] i_tdata = '0;
    logic        i_tuser = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast, o_teob, o_tvalid;
    logic        o_tready = 1'b1;
    logic [7:0]  frame_cnt;
    logic        busy;

    ofdm_periodic_framer dut (
        .ce_clk(ce_clk), .ce_rst(ce_rst),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_teob(o_teob), .o_tvalid(o_tvalid),
        .o_tready(o_tready), .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 ce_clk = ~ce_clk;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic        e;
    } beat_t;

    beat_t exp_q[$];
    int    compared = 0;
    int    mismatched = 0;
    bit    rnd_rdy = 0;
    bit    rnd_idle = 0;

    // Expected beats of one burst over a ramp 0..n-1 triggered at sample t.
    function automatic void push_burst(int n, int t, int off, int len, int gap, int maxf);
        int k = 0;
        int s;
        while (1) begin
            if (maxf != 0 && k >= maxf) break;
            s = t + off + k * (len + gap);
            if (s >= n) break;
            for (int j = 0; j < len && s + j < n; j++) begin
                beat_t b;
                b.d = 32'(s + j);
                b.l = (j == len - 1);
                b.e = b.l && (maxf != 0) && (k == maxf - 1);
                exp_q.push_back(b);
            end
            k++;
        end
    endfunction

    always @(negedge ce_clk) begin
        if (ce_rst && o_tvalid && o_tready) begin
            beat_t e;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL beat: unexpected output d=%0d last=%0b eob=%0b", o_tdata, o_tlast, o_teob);
            end else begin
                e = exp_q.pop_front();
                if (o_tdata !== e.d || o_tlast !== e.l || o_teob !== e.e) begin
                    mismatched++;
                    $display("FAIL beat: got d=%0d last=%0b eob=%0b, expected d=%0d last=%0b eob=%0b",
                             o_tdata, o_tlast, o_teob, e.d, e.l, e.e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge ce_clk);
            #1;
            o_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input int act, input int expv);
        compared++;
        if (act != expv) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic do_reset();
        ce_rst   = 1'b0;
        i_tvalid = 1'b0;
        i_tuser  = 1'b0;
        set_stb  = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge ce_clk);
        #1;
        ce_rst = 1'b1;
        @(posedge ce_clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        @(posedge ce_clk);
        #1;
        set_stb = 1'b0;
    endtask

    task automatic send(input logic [31:0] v, input logic u);
        int guard = 0;
        bit done = 0;
        i_tdata  = v;
        i_tuser  = u;
        i_tvalid = 1'b1;
        while (!done) begin
            @(negedge ce_clk);
            if (i_tready) done = 1;
            else if (++guard > 1000) begin
                mismatched++;
                $display("FAIL handshake: i_tready stuck low at sample %0d", v);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
                $fatal(1, "input handshake timeout");
            end
            @(posedge ce_clk);
            #1;
        end
    endtask

    task automatic stream(input int n, input int t1, input int t2, input int wi,
                          input logic [7:0] wa, input logic [31:0] wd);
        for (int i = 0; i < n; i++) begin
            if (rnd_idle && $urandom_range(0, 7) == 0) begin
                i_tvalid = 1'b0;
                @(posedge ce_clk);
                #1;
            end
            if (i == wi) begin
                set_stb  = 1'b1;
                set_addr = wa;
                set_data = wd;
            end
            send(32'(i), (i == t1) || (i == t2));
            set_stb = 1'b0;
        end
        i_tvalid = 1'b0;
        i_tuser  = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (20) @(posedge ce_clk);
        #1;
        check({name, " leftover"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        do_reset();
        i_tvalid = 1'b1;
        #1;
        check("reset busy", int'(busy), 0);
        check("reset frame_cnt", int'(frame_cnt), 0);
        check("reset o_tvalid", int'(o_tvalid), 0);
        check("reset o_tlast", int'(o_tlast), 0);
        check("reset o_teob", int'(o_teob), 0);
        i_tvalid = 1'b0;
        @(posedge ce_clk);
        #1;

        // Defaults with offset 30, two frames.
        wr(BASE + 8'd3, 2);
        wr(BASE + 8'd2, 30);
        push_burst(300, 100, 30, 64, 16, 2);
        stream(300, 100, -1, -1, 8'h0, 0);
        drain("t1");
        check("t1 frame_cnt", int'(frame_cnt), 2);
        check("t1 busy", int'(busy), 0);

        // Zero offset and zero gap: contiguous frames.
        do_reset();
        wr(BASE + 8'd0, 4);
        wr(BASE + 8'd1, 0);
        wr(BASE + 8'd3, 3);
        push_burst(40, 5, 0, 4, 0, 3);
        stream(40, 5, -1, -1, 8'h0, 0);
        drain("t2");
        check("t2 frame_cnt", int'(frame_cnt), 3);

        // First case again under random backpressure and input bubbles.
        do_reset();
        rnd_rdy  = 1;
        rnd_idle = 1;
        wr(BASE + 8'd3, 2);
        wr(BASE + 8'd2, 30);
        push_burst(300, 100, 30, 64, 16, 2);
        stream(300, 100, -1, -1, 8'h0, 0);
        drain("t3");
        check("t3 frame_cnt", int'(frame_cnt), 2);
        rnd_rdy  = 0;
        rnd_idle = 0;

        // frame_len rewritten mid-burst only affects the next burst.
        do_reset();
        wr(BASE + 8'd3, 2);
        wr(BASE + 8'd2, 30);
        push_burst(600, 100, 30, 64, 16, 2);
        push_burst(600, 400, 30, 32, 16, 2);
        stream(600, 100, 400, 150, BASE + 8'd0, 32);
        drain("t4");
        check("t4 frame_cnt", int'(frame_cnt), 2);

        // frame_len 0 behaves as 1; trigger sample is itself a whole frame.
        do_reset();
        wr(BASE + 8'd0, 0);
        wr(BASE + 8'd1, 1);
        wr(BASE + 8'd3, 3);
        push_burst(20, 2, 0, 1, 1, 3);
        stream(20, 2, -1, -1, 8'h0, 0);
        drain("t5");
        check("t5 frame_cnt", int'(frame_cnt), 3);

        // Unlimited mode past 300 frames, then asynchronous reset mid-frame.
        do_reset();
        wr(BASE + 8'd0, 8);
        wr(BASE + 8'd1, 2);
        push_burst(3095, 0, 0, 8, 2, 0);
        stream(3095, 0, -1, -1, 8'h0, 0);
        drain("t6");
        check("t6 frame_cnt sat", int'(frame_cnt), 255);
        check("t6 busy", int'(busy), 1);
        i_tdata  = 32'd5000;
        i_tvalid = 1'b1;
        #2;
        ce_rst = 1'b0;
        #1;
        check("t6 rst busy", int'(busy), 0);
        check("t6 rst o_tvalid", int'(o_tvalid), 0);
        check("t6 rst frame_cnt", int'(frame_cnt), 0);
        i_tvalid = 1'b0;

        // Second trigger during the gap.
        do_reset();
        wr(BASE + 8'd3, 2);
        wr(BASE + 8'd2, 30);
`ifdef OFDM_FRAMER_RETRIGGER_EN
        push_burst(200, 100, 30, 64, 16, 2);
        push_burst(400, 200, 30, 64, 16, 2);
`else
        push_burst(400, 100, 30, 64, 16, 2);
`endif
        stream(400, 100, 200, -1, 8'h0, 0);
        drain("t7");
        check("t7 frame_cnt", int'(frame_cnt), 2);
        check("t7 busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
